// File: rtl/fnd_pkg.sv
// Shared definitions for the six-digit FND display path: glyph patterns,
// digit positions on the scan bus, receiver error codes and FSM states.
package fnd_pkg;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1110011;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_GLYPH = 2'd1,
    ERR_SEQ   = 2'd2,
    ERR_RANGE = 2'd3
  } err_code_e;

  // COLn encodes "next expected digit index n", so the state value doubles
  // as the index to compare against.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COL1  = 3'd1,
    ST_COL2  = 3'd2,
    ST_COL3  = 3'd3,
    ST_COL4  = 3'd4,
    ST_COL5  = 3'd5,
    ST_CHECK = 3'd6
  } rx_state_e;

  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens,
                                            input logic [3:0] ones);
    logic [5:0] t6;
    t6 = {2'b00, tens};
    return t6 * 6'd10 + {2'b00, ones};
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Inverse of the display encoder: maps a 7-segment glyph back to its decimal
// digit and flags any pattern the encoder can never produce.
module seg_to_bcd
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      GLYPH_0: digit = 4'd0;
      GLYPH_1: digit = 4'd1;
      GLYPH_2: digit = 4'd2;
      GLYPH_3: digit = 4'd3;
      GLYPH_4: digit = 4'd4;
      GLYPH_5: digit = 4'd5;
      GLYPH_6: digit = 4'd6;
      GLYPH_7: digit = 4'd7;
      GLYPH_8: digit = 4'd8;
      GLYPH_9: digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Scan-side receiver for the multiplexed FND bus: filters digit dwells,
// reassembles an HH:MM:SS frame and reports it or the first error found.
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_seg,
  input  logic       i_seg_dp,
  input  logic [5:0] i_seg_enb,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [5:0] o_dp,
  output logic       o_frame_vld,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

  logic [6:0] seg_q;
  logic       dp_q;
  logic [5:0] enb_q;
  logic [7:0] dwell_cnt;
  logic       accept;

  // The counter scores the sample being registered on this edge, so it
  // reaches SETTLE on the SETTLE_CYC-th edge that sees the new enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      dp_q      <= 1'b0;
      enb_q     <= '1;
      dwell_cnt <= '0;
      accept    <= 1'b0;
    end else begin
      seg_q <= i_seg;
      dp_q  <= i_seg_dp;
      enb_q <= i_seg_enb;
      if (i_seg_enb != enb_q) begin
        dwell_cnt <= 8'd1;
      end else if (dwell_cnt != SETTLE) begin
        dwell_cnt <= dwell_cnt + 8'd1;
      end
      accept <= (i_seg_enb == enb_q) && (dwell_cnt == SETTLE - 8'd1);
    end
  end

  // Enable decode: blank, multiple-low, or the index of the single low bit.
  logic [5:0] enb_low;
  logic       is_blank;
  logic       is_multi;
  logic [2:0] idx;

  assign enb_low  = ~enb_q;
  assign is_blank = (enb_q == 6'h3F);
  assign is_multi = |(enb_low & (enb_low - 6'd1));

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (enb_low[k]) idx = 3'(k);
    end
  end

  logic       glyph_ok;
  logic [3:0] glyph_val;

  seg_to_bcd u_seg_to_bcd (
    .seg   (seg_q),
    .valid (glyph_ok),
    .digit (glyph_val)
  );

  // NOTE: the digit store has no reset; every entry is rewritten by the
  // current frame before CHECK reads it.
  logic [3:0] dig [NUM_DIGITS];
  logic [5:0] dp_st;
  logic       store_en;

  always_ff @(posedge clk) begin
    if (store_en) begin
      dig[idx]   <= glyph_val;
      dp_st[idx] <= dp_q;
    end
  end

  logic [5:0] hour_val;
  logic [5:0] min_val;
  logic [5:0] sec_val;
  logic       range_ok;

  assign hour_val = bcd_to_bin(dig[DIG_HOUR_TENS], dig[DIG_HOUR_ONES]);
  assign min_val  = bcd_to_bin(dig[DIG_MIN_TENS],  dig[DIG_MIN_ONES]);
  assign sec_val  = bcd_to_bin(dig[DIG_SEC_TENS],  dig[DIG_SEC_ONES]);
  assign range_ok = (dig[DIG_HOUR_TENS] <= 4'd2) && (hour_val <= 6'd23) &&
                    (dig[DIG_MIN_TENS]  <= 4'd5) && (dig[DIG_SEC_TENS] <= 4'd5);

  rx_state_e state;
  rx_state_e state_nxt;
  logic      err_set;
  err_code_e err_nxt;
  logic      frame_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    store_en   = 1'b0;
    err_set    = 1'b0;
    err_nxt    = ERR_NONE;
    frame_load = 1'b0;
    if (state == ST_CHECK) begin
      state_nxt = ST_IDLE;
      if (range_ok) begin
        frame_load = 1'b1;
      end else begin
        err_set = 1'b1;
        err_nxt = ERR_RANGE;
      end
    end else if (accept && !is_blank) begin
      if (state == ST_IDLE && !is_multi && idx != DIG_SEC_ONES) begin
        // Waiting for a frame start: mid-scan digits are not errors.
        state_nxt = ST_IDLE;
      end else if (!glyph_ok) begin
        err_set   = 1'b1;
        err_nxt   = ERR_GLYPH;
        state_nxt = ST_IDLE;
      end else if (is_multi) begin
        err_set   = 1'b1;
        err_nxt   = ERR_SEQ;
        state_nxt = ST_IDLE;
      end else if (idx == DIG_SEC_ONES) begin
        store_en  = 1'b1;
        state_nxt = ST_COL1;
        if (state != ST_IDLE) begin
          err_set = 1'b1;
          err_nxt = ERR_SEQ;
        end
      end else if (idx == 3'(state)) begin
        store_en  = 1'b1;
        state_nxt = (state == ST_COL5) ? ST_CHECK : rx_state_e'(state + 3'd1);
      end else begin
        err_set   = 1'b1;
        err_nxt   = ERR_SEQ;
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hour      <= '0;
      o_min       <= '0;
      o_sec       <= '0;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
    end else begin
      o_frame_vld <= frame_load;
      o_err       <= err_set;
      if (frame_load) begin
        o_hour <= hour_val;
        o_min  <= min_val;
        o_sec  <= sec_val;
        o_dp   <= dp_st;
      end
      if (err_set) o_err_code <= err_nxt;
    end
  end

endmodule

// File: doc/fnd_scan_rx.md
# fnd_scan_rx

Scan-side receiver for the six-digit multiplexed FND bus. It samples the time-multiplexed segment, decimal-point and active-low digit-enable lines produced by the display multiplexer and reassembles a full HH:MM:SS frame, returning binary hour/minute/second values. It sits beside the clock top level as an in-system monitor/self-check of the display path. It also feeds the verification environment as a scoreboard probe.

## Interface
- SETTLE_CYC, 4: consecutive identical samples of the enable bus required before a digit is accepted (2..255).
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- i_seg  in  7  segment pattern {a..g}, active-high
- i_seg_dp  in  1  decimal point of the currently enabled digit
- i_seg_enb  in  6  digit enables, active-low, one-hot-low when valid
- o_hour  out  6  last good hour, 0..23
- o_min  out  6  last good minute, 0..59
- o_sec  out  6  last good second, 0..59
- o_dp  out  6  dp bits of the last good frame, bit k = digit k
- o_frame_vld  out  1  one-cycle pulse: new good frame on outputs
- o_err  out  1  one-cycle pulse: error detected
- o_err_code  out  2  code of most recent error (1 glyph, 2 sequence/enable, 3 range); 0 = none since reset

## Operation
- Digit map, by low enable bit k: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens. Scan order is 0,1,...,5,0,...
- All inputs registered once. Dwell counter increments while the registered enable equals the previous sample and saturates at SETTLE_CYC. The counter reloads to 1 on any change.
- Acceptance: exactly one accept per dwell, on the edge where the counter reaches SETTLE_CYC. The segment and dp values are taken from the same registered sample.
- Enable 6'b111111 (blank) never accepts and does not disturb the frame.
- Enable with two or more low bits: at acceptance -> error code 2, frame discarded.
- Glyph decode is the inverse of the display encoder:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
  - Any other pattern -> error code 1, frame discarded.
- FSM states: IDLE, COLLECT(n) with n = next expected index 1..5, CHECK.
  - IDLE: accept of digit 0 -> store, go to COLLECT(1). Other indices are ignored silently, with no error.
  - COLLECT(n): accept of index n -> store. n<5 -> COLLECT(n+1); n=5 -> CHECK.
  - COLLECT(n): accept of index 0 -> error code 2, restart as if in IDLE with digit 0 stored.
  - COLLECT(n): any other index -> error code 2, go to IDLE.
  - CHECK (one cycle): range check passes -> load outputs, pulse o_frame_vld, go to IDLE. Fail -> error code 3, outputs unchanged, go to IDLE.
  - Range check: hour tens ≤2, hour ≤23, min/sec tens ≤5.
- Arithmetic: value = tens*10 + ones, computed in 6 bits; inputs are bounded so no overflow.
- Outputs hold their values between frames. Wrap 23:59:59 -> 00:00:00 is an ordinary frame.

## Timing
- Reset values: o_hour/o_min/o_sec/o_dp = 0, o_frame_vld = 0, o_err = 0, o_err_code = 0, FSM = IDLE, dwell counter = 0.
- Reset is effective immediately at any point; a partial frame is discarded.
- Accept occurs SETTLE_CYC cycles after the enable change reaches the pins (1 register stage + SETTLE_CYC-1 compares).
- o_frame_vld and the new output values appear 2 cycles after digit 5 is accepted: accept -> CHECK -> outputs registered.
- o_err fires 1 cycle after the offending accept (or after CHECK, for range errors). o_err_code updates in the same cycle and holds until the next error.
- Simultaneous error and frame valid are impossible by construction. Only one error is reported per accept; the glyph check has priority over the sequence check.
- Dwells shorter than SETTLE_CYC are ignored, which filters mux glitches.

## Structure
- Shared package fnd_pkg holds:
  - the ten glyph constants (shared with the display encoder);
  - digit-index constants DIG_SEC_ONES..DIG_HOUR_TENS;
  - error codes ERR_NONE, ERR_GLYPH, ERR_SEQ, ERR_RANGE.
- One sub-module, seg_to_bcd: combinational 7-bit glyph -> {valid, 4-bit digit}.
- Top-level fnd_scan_rx contains the input register, dwell counter, one-hot-low enable decode, FSM, digit store and output registers.

## Test plan
- Steady display of 12:34:56, SETTLE_CYC=4, 5000-cycle dwells -> o_frame_vld once per scan; hour=12, min=34, sec=56; o_err never asserted.
- Display 23:59:59 followed by 00:00:00 -> consecutive frames report 23/59/59 then 0/0/0.
- Glyph 7'b0000001 on digit 2 -> o_err pulse, code 1; outputs keep the previous frame; next clean scan produces a valid frame.
- Scan order 0,1,3 -> code 2, FSM returns to IDLE; a 0,1,2 scan mid-frame followed by digit 0 -> code 2 and collection restarts from digit 0.
- Hour tens 2, ones 7 (27) -> code 3, outputs unchanged. Enable 6'b111100 held -> code 2. 3-cycle enable glitch -> ignored.
- Assert rst_n low after digit 3 is accepted -> all outputs 0; first frame after release is a complete 0..5 scan.
